// File: rtl/router_tx_controller.sv
// Waveguide transmit front end: packet FIFO, arbiter request/grant handshake, flit serializer.
// Grant at edge T gives flits in cycles T+1..T+NFLITS and done in T+NFLITS+1; in_ready_o is low while the FIFO is full.

module router_tx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

module router_tx_controller #(
  parameter int PKT_WIDTH  = 64,
  parameter int FLIT_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  input  logic [PKT_WIDTH-1:0]            in_data_i,
  output logic                            in_ready_o,
  output logic                            request_o,
  input  logic                            grant_i,
  output logic                            done_o,
  output logic                            tx_valid_o,
  output logic [FLIT_WIDTH-1:0]           tx_data_o,
  output logic                            tx_last_o,
  output logic [CNT_WIDTH-1:0]            pkts_sent_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);
  localparam int NFLITS = PKT_WIDTH / FLIT_WIDTH;
  localparam int IDX_W  = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [CNT_WIDTH-1:0]                pkts_q, pkts_d;
  logic                                fifo_full;
  logic                                fifo_pop;
  logic [PKT_WIDTH-1:0]                head;
  logic [NFLITS-1:0][FLIT_WIDTH-1:0]   head_flits;

  assign in_ready_o  = !fifo_full;
  assign pkts_sent_o = pkts_q;
  assign head_flits  = head;

  router_tx_fifo #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (in_valid_i && in_ready_o),
    .push_dat_i (in_data_i),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .count_o    (fifo_count_o),
    .full_o     (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkts_d     = pkts_q;
    fifo_pop   = 1'b0;
    request_o  = 1'b0;
    done_o     = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    tx_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is only honoured while we are actually requesting.
        request_o = (fifo_count_o != '0);
        if (request_o && grant_i) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = head_flits[idx_q];
        tx_last_o  = (idx_q == LAST_IDX);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        done_o   = 1'b1;
        fifo_pop = 1'b1;
        pkts_d   = pkts_q + CNT_WIDTH'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pkts_q  <= pkts_d;
    end
  end
endmodule

// File: tb/tb_router_tx_controller.sv
// Directed bench for router_tx_controller: single instance scenarios plus a two-router arbitration case.

module tb_router_tx_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, request, grant, done, tx_valid, tx_last;
  logic [63:0] in_data;
  logic [15:0] tx_data, pkts_sent;
  logic [2:0]  fifo_count;

  router_tx_controller u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .request_o(request), .grant_i(grant), .done_o(done),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_last_o(tx_last),
    .pkts_sent_o(pkts_sent), .fifo_count_o(fifo_count)
  );

  // Two routers sharing a fixed-priority arbiter (router 0 wins).
  logic        a_rst;
  logic [1:0]  a_in_valid, a_in_ready, a_req, a_grant, a_done, a_tx_valid, a_tx_last;
  logic [63:0] a_in_data [2];
  logic [15:0] a_tx_data [2];
  logic [15:0] a_pkts [2];
  logic [2:0]  a_cnt [2];
  logic        arb_busy_q, arb_owner_q;

  router_tx_controller u_r0 (
    .clk_i(clk), .rst_i(a_rst), .in_valid_i(a_in_valid[0]), .in_data_i(a_in_data[0]),
    .in_ready_o(a_in_ready[0]), .request_o(a_req[0]), .grant_i(a_grant[0]), .done_o(a_done[0]),
    .tx_valid_o(a_tx_valid[0]), .tx_data_o(a_tx_data[0]), .tx_last_o(a_tx_last[0]),
    .pkts_sent_o(a_pkts[0]), .fifo_count_o(a_cnt[0])
  );
  router_tx_controller u_r1 (
    .clk_i(clk), .rst_i(a_rst), .in_valid_i(a_in_valid[1]), .in_data_i(a_in_data[1]),
    .in_ready_o(a_in_ready[1]), .request_o(a_req[1]), .grant_i(a_grant[1]), .done_o(a_done[1]),
    .tx_valid_o(a_tx_valid[1]), .tx_data_o(a_tx_data[1]), .tx_last_o(a_tx_last[1]),
    .pkts_sent_o(a_pkts[1]), .fifo_count_o(a_cnt[1])
  );

  assign a_grant[0] = !arb_busy_q && a_req[0];
  assign a_grant[1] = !arb_busy_q && !a_req[0] && a_req[1];

  always_ff @(posedge clk) begin
    if (a_rst) begin
      arb_busy_q  <= 1'b0;
      arb_owner_q <= 1'b0;
    end else if (!arb_busy_q && (a_grant != 2'b00)) begin
      arb_busy_q  <= 1'b1;
      arb_owner_q <= a_grant[1];
    end else if (arb_busy_q && a_done[arb_owner_q]) begin
      arb_busy_q  <= 1'b0;
    end
  end

  int nvec = 0;
  int nerr = 0;
  logic [63:0] pk [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    grant    = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  task automatic push_pkt(input logic [63:0] p);
    in_valid = 1'b1;
    in_data  = p;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b0;
    grant    = 1'b0;
    rst      = 1'b1;
    tick();
    nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL rst_request: got %b want 0", request); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    nvec++; if (tx_last !== 1'b0) begin nerr++; $display("FAIL rst_tx_last: got %b want 0", tx_last); end
    nvec++; if (tx_data !== 16'h0) begin nerr++; $display("FAIL rst_tx_data: got %h want 0000", tx_data); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL rst_fifo_count: got %0d want 0", fifo_count); end
    nvec++; if (pkts_sent !== 16'd0) begin nerr++; $display("FAIL rst_pkts_sent: got %0d want 0", pkts_sent); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [15:0] ef [4];
    ef = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    do_reset();
    push_pkt(64'h4444_3333_2222_1111);
    nvec++; if (request !== 1'b1) begin nerr++; $display("FAIL single_req_rise: got %b want 1", request); end
    nvec++; if (fifo_count !== 3'd1) begin nerr++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    tick();
    nvec++; if (request !== 1'b1) begin nerr++; $display("FAIL single_req_hold: got %b want 1", request); end
    grant = 1'b1;
    tick();
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL single_valid[%0d]: got %b want 1", i, tx_valid); end
      nvec++; if (tx_data !== ef[i]) begin nerr++; $display("FAIL single_data[%0d]: got %h want %h", i, tx_data, ef[i]); end
      nvec++; if (tx_last !== (i == 3)) begin nerr++; $display("FAIL single_last[%0d]: got %b want %b", i, tx_last, (i == 3)); end
      nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL single_req_low[%0d]: got %b want 0", i, request); end
      tick();
    end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL single_done: got %b want 1", done); end
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL single_done_valid: got %b want 0", tx_valid); end
    tick();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL single_done_pulse: got %b want 0", done); end
    nvec++; if (pkts_sent !== 16'd1) begin nerr++; $display("FAIL single_pkts: got %0d want 1", pkts_sent); end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
    nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL single_req_idle: got %b want 0", request); end
  endtask

  task automatic test_fifo_full;
    logic [63:0] cur;
    do_reset();
    for (int k = 0; k < 4; k++) push_pkt(pk[k]);
    nvec++; if (fifo_count !== 3'd4) begin nerr++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = pk[4];
    tick();
    in_valid = 1'b0;
    nvec++; if (fifo_count !== 3'd4) begin nerr++; $display("FAIL full_5th_reject: got %0d want 4", fifo_count); end
    for (int k = 0; k < 4; k++) begin
      cur   = pk[k];
      grant = 1'b1;
      tick();
      grant = 1'b0;
      for (int j = 0; j < 4; j++) begin
        nvec++; if (tx_data !== cur[16*j +: 16]) begin nerr++; $display("FAIL full_order[%0d][%0d]: got %h want %h", k, j, tx_data, cur[16*j +: 16]); end
        tick();
      end
      nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL full_done[%0d]: got %b want 1", k, done); end
      tick();
    end
    nvec++; if (pkts_sent !== 16'd4) begin nerr++; $display("FAIL full_pkts: got %0d want 4", pkts_sent); end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_full_done;
    logic [63:0] cur;
    do_reset();
    for (int k = 0; k < 4; k++) push_pkt(pk[k]);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    repeat (4) tick();
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL fd_done: got %b want 1", done); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL fd_no_bypass: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = pk[4];
    tick();
    nvec++; if (fifo_count !== 3'd3) begin nerr++; $display("FAIL fd_count3: got %0d want 3", fifo_count); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL fd_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    nvec++; if (fifo_count !== 3'd4) begin nerr++; $display("FAIL fd_count4: got %0d want 4", fifo_count); end
    for (int k = 1; k < 5; k++) begin
      cur   = pk[k];
      grant = 1'b1;
      tick();
      grant = 1'b0;
      nvec++; if (tx_data !== cur[15:0]) begin nerr++; $display("FAIL fd_head[%0d]: got %h want %h", k, tx_data, cur[15:0]); end
      repeat (3) tick();
      nvec++; if (tx_last !== 1'b1) begin nerr++; $display("FAIL fd_last[%0d]: got %b want 1", k, tx_last); end
      tick();
      tick();
    end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL fd_single_push: got %0d want 0", fifo_count); end
    nvec++; if (pkts_sent !== 16'd5) begin nerr++; $display("FAIL fd_pkts: got %0d want 5", pkts_sent); end
  endtask

  task automatic test_spurious_grant;
    logic [63:0] cur;
    cur = pk[2];
    do_reset();
    grant = 1'b1;
    tick();
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL sg_empty_valid: got %b want 0", tx_valid); end
    nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL sg_empty_req: got %b want 0", request); end
    tick();
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL sg_empty_valid2: got %b want 0", tx_valid); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL sg_empty_done: got %b want 0", done); end
    grant = 1'b0;
    push_pkt(cur);
    nvec++; if (request !== 1'b1) begin nerr++; $display("FAIL sg_req: got %b want 1", request); end
    grant = 1'b1;
    tick();
    // Grant stays high through SEND, DONE and the following idle cycles.
    for (int j = 0; j < 4; j++) begin
      nvec++; if (tx_data !== cur[16*j +: 16]) begin nerr++; $display("FAIL sg_flit[%0d]: got %h want %h", j, tx_data, cur[16*j +: 16]); end
      tick();
    end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL sg_done: got %b want 1", done); end
    for (int j = 0; j < 3; j++) begin
      tick();
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL sg_extra_done[%0d]: got %b want 0", j, done); end
      nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL sg_extra_valid[%0d]: got %b want 0", j, tx_valid); end
    end
    grant = 1'b0;
    nvec++; if (pkts_sent !== 16'd1) begin nerr++; $display("FAIL sg_pkts: got %0d want 1", pkts_sent); end
  endtask

  task automatic test_reset_midsend;
    logic [63:0] cur;
    cur = pk[0];
    do_reset();
    push_pkt(pk[0]);
    push_pkt(pk[1]);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    tick();
    tick();
    nvec++; if (tx_data !== cur[47:32]) begin nerr++; $display("FAIL rm_flit2: got %h want %h", tx_data, cur[47:32]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rm_valid: got %b want 0", tx_valid); end
    nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL rm_req: got %b want 0", request); end
    nvec++; if (fifo_count !== 3'd0) begin nerr++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
    nvec++; if (pkts_sent !== 16'd0) begin nerr++; $display("FAIL rm_pkts: got %0d want 0", pkts_sent); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rm_ready: got %b want 1", in_ready); end
    for (int j = 0; j < 6; j++) begin
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rm_done[%0d]: got %b want 0", j, done); end
      nvec++; if (request !== 1'b0) begin nerr++; $display("FAIL rm_req_after[%0d]: got %b want 0", j, request); end
      tick();
    end
  endtask

  task automatic test_two_routers;
    logic ev0, ev1, ed0, ed1, er1;
    a_in_valid = 2'b00;
    a_rst      = 1'b1;
    tick();
    a_rst        = 1'b0;
    a_in_data[0] = 64'h0A03_0A02_0A01_0A00;
    a_in_data[1] = 64'h0B03_0B02_0B01_0B00;
    a_in_valid   = 2'b11;
    tick();
    a_in_valid   = 2'b00;
    for (int k = 0; k < 13; k++) begin
      ev0 = (k >= 1 && k <= 4);
      ev1 = (k >= 7 && k <= 10);
      ed0 = (k == 5);
      ed1 = (k == 11);
      er1 = (k <= 6);
      nvec++; if ((a_tx_valid[0] & a_tx_valid[1]) !== 1'b0) begin nerr++; $display("FAIL arb_overlap[%0d]: got %b want 0", k, a_tx_valid[0] & a_tx_valid[1]); end
      nvec++; if (a_tx_valid[0] !== ev0) begin nerr++; $display("FAIL arb_valid0[%0d]: got %b want %b", k, a_tx_valid[0], ev0); end
      nvec++; if (a_tx_valid[1] !== ev1) begin nerr++; $display("FAIL arb_valid1[%0d]: got %b want %b", k, a_tx_valid[1], ev1); end
      nvec++; if (a_done[0] !== ed0) begin nerr++; $display("FAIL arb_done0[%0d]: got %b want %b", k, a_done[0], ed0); end
      nvec++; if (a_done[1] !== ed1) begin nerr++; $display("FAIL arb_done1[%0d]: got %b want %b", k, a_done[1], ed1); end
      nvec++; if (a_req[1] !== er1) begin nerr++; $display("FAIL arb_req1[%0d]: got %b want %b", k, a_req[1], er1); end
      if (ev0) begin
        nvec++; if (a_tx_data[0] !== 16'h0A00 + 16'(k - 1)) begin nerr++; $display("FAIL arb_data0[%0d]: got %h want %h", k, a_tx_data[0], 16'h0A00 + 16'(k - 1)); end
      end
      if (ev1) begin
        nvec++; if (a_tx_data[1] !== 16'h0B00 + 16'(k - 7)) begin nerr++; $display("FAIL arb_data1[%0d]: got %h want %h", k, a_tx_data[1], 16'h0B00 + 16'(k - 7)); end
      end
      tick();
    end
    nvec++; if (a_pkts[0] !== 16'd1) begin nerr++; $display("FAIL arb_pkts0: got %0d want 1", a_pkts[0]); end
    nvec++; if (a_pkts[1] !== 16'd1) begin nerr++; $display("FAIL arb_pkts1: got %0d want 1", a_pkts[1]); end
  endtask

  initial begin
    pk[0] = 64'hA003_A002_A001_A000;
    pk[1] = 64'hB003_B002_B001_B000;
    pk[2] = 64'hC003_C002_C001_C000;
    pk[3] = 64'hD003_D002_D001_D000;
    pk[4] = 64'hE003_E002_E001_E000;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    grant        = 1'b0;
    a_rst        = 1'b1;
    a_in_valid   = 2'b00;
    a_in_data[0] = '0;
    a_in_data[1] = '0;
    test_reset();
    test_single();
    test_fifo_full();
    test_full_done();
    test_spurious_grant();
    test_reset_midsend();
    test_two_routers();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
